plane_mapper: RTL

Converts the signed, centre-origin pixel coordinate stream from the raster coordinate generator into fixed-point complex-plane coordinates (Q8.24) for the downstream iteration engine. Applies frame-synchronous pan (centre) and power-of-two zoom, passes sof/eol sideband through, and provides valid/ready flow control in both directions. Sits between the coordinate generator and the per-pixel compute core.

---
 rtl/plane_mapper.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/plane_mapper.sv
// plane_mapper
//   Maps signed, centre-origin pixel coordinates to Q8.24 complex-plane
//   coordinates: re = cx + (x << (16-z)), im = cy + (y << (16-z)), with the
//   zoom code z clamped to ZOOM_MAX. Pan/zoom are staged through pending
//   registers (cfg_update) and become active on the next accepted sof beat,
//   so a frame is always mapped with one consistent configuration.
//   Two-stage pipeline with valid/ready flow control; sof/eol ride along.
//
// Build option:
//   PLANE_MAPPER_SAT_EN  defined   -> shifted terms and sums saturate to the
//                                     OUT_W signed range
//                        undefined -> results wrap modulo 2^OUT_W
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   s_x, s_y           signed pixel coordinates (IN_W)
//   s_sof, s_eol       first pixel of frame / last pixel of line
//   s_valid, s_ready   input handshake (s_ready depends on m_ready, m_valid only)
//   cfg_cx, cfg_cy     pan centre, Q8.24
//   cfg_zoom           zoom code
//   cfg_update         strobe: capture cfg_* into pending registers
//   m_re, m_im         plane coordinates, Q8.24
//   m_sof, m_eol       sideband aligned with m_re/m_im
//   m_valid, m_ready   output handshake
module plane_mapper #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int FRAC     = 24,
  parameter int ZOOM_MAX = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IN_W-1:0]  s_x,
  input  logic [IN_W-1:0]  s_y,
  input  logic             s_sof,
  input  logic             s_eol,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [OUT_W-1:0] cfg_cx,
  input  logic [OUT_W-1:0] cfg_cy,
  input  logic [4:0]       cfg_zoom,
  input  logic             cfg_update,
  output logic [OUT_W-1:0] m_re,
  output logic [OUT_W-1:0] m_im,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_valid,
  input  logic             m_ready
);

  // Pixel pitch at zoom 0 is 2^-8 plane units, i.e. 2^(FRAC-8) LSB.
  localparam logic [4:0] PITCH0 = 5'(FRAC - 8);
  localparam logic [4:0] ZMAX   = 5'(ZOOM_MAX);

  logic [OUT_W-1:0] pend_cx, pend_cy, act_cx, act_cy;
  logic [4:0]       pend_zoom, act_zoom;

  logic             en, accept, sof_acc;
  logic [OUT_W-1:0] use_cx, use_cy;
  logic [4:0]       use_zoom, z_clamp, shamt;
  logic [OUT_W:0]   x_ext, y_ext, shx_raw, shy_raw, shx_c, shy_c;

  // Stage 1
  logic             v1, sof1, eol1;
  logic [OUT_W:0]   shx1, shy1;
  logic [OUT_W-1:0] cx1, cy1;

  // Stage 2
  logic             v2;

`ifdef PLANE_MAPPER_SAT_EN
  function automatic logic [OUT_W-1:0] fit(input logic [OUT_W:0] v);
    if (v[OUT_W] != v[OUT_W-1])
      return v[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      return v[OUT_W-1:0];
  endfunction
  logic [OUT_W-1:0] shx_fit, shy_fit;
`endif

  assign en      = m_ready || !v2;
  assign s_ready = en;
  assign m_valid = v2;
  assign accept  = s_valid && en;
  assign sof_acc = accept && s_sof;

  // The sof beat itself must already use the newly activated config, and a
  // strobe in that same cycle must win over the older pending values.
  always_comb begin
    use_cx   = act_cx;
    use_cy   = act_cy;
    use_zoom = act_zoom;
    if (sof_acc) begin
      if (cfg_update) begin
        use_cx   = cfg_cx;
        use_cy   = cfg_cy;
        use_zoom = cfg_zoom;
      end else begin
        use_cx   = pend_cx;
        use_cy   = pend_cy;
        use_zoom = pend_zoom;
      end
    end
  end

  always_comb begin
    z_clamp = (use_zoom > ZMAX) ? ZMAX : use_zoom;
    shamt   = PITCH0 - z_clamp;
    x_ext   = {{(OUT_W + 1 - IN_W){s_x[IN_W-1]}}, s_x};
    y_ext   = {{(OUT_W + 1 - IN_W){s_y[IN_W-1]}}, s_y};
    shx_raw = x_ext << shamt;
    shy_raw = y_ext << shamt;
  end

`ifdef PLANE_MAPPER_SAT_EN
  always_comb begin
    shx_fit = fit(shx_raw);
    shy_fit = fit(shy_raw);
    shx_c   = {shx_fit[OUT_W-1], shx_fit};
    shy_c   = {shy_fit[OUT_W-1], shy_fit};
  end
`else
  always_comb begin
    shx_c = shx_raw;
    shy_c = shy_raw;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_cx   <= '0;
      pend_cy   <= '0;
      pend_zoom <= '0;
      act_cx    <= '0;
      act_cy    <= '0;
      act_zoom  <= '0;
    end else begin
      if (cfg_update) begin
        pend_cx   <= cfg_cx;
        pend_cy   <= cfg_cy;
        pend_zoom <= cfg_zoom;
      end
      if (sof_acc) begin
        act_cx   <= use_cx;
        act_cy   <= use_cy;
        act_zoom <= use_zoom;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1   <= 1'b0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
      shx1 <= '0;
      shy1 <= '0;
      cx1  <= '0;
      cy1  <= '0;
    end else if (en) begin
      v1   <= s_valid;
      sof1 <= s_sof;
      eol1 <= s_eol;
      shx1 <= shx_c;
      shy1 <= shy_c;
      cx1  <= use_cx;
      cy1  <= use_cy;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v2    <= 1'b0;
      m_sof <= 1'b0;
      m_eol <= 1'b0;
      m_re  <= '0;
      m_im  <= '0;
    end else if (en) begin
      v2    <= v1;
      m_sof <= sof1;
      m_eol <= eol1;
`ifdef PLANE_MAPPER_SAT_EN
      m_re  <= fit({cx1[OUT_W-1], cx1} + shx1);
      m_im  <= fit({cy1[OUT_W-1], cy1} + shy1);
`else
      m_re  <= OUT_W'({cx1[OUT_W-1], cx1} + shx1);
      m_im  <= OUT_W'({cy1[OUT_W-1], cy1} + shy1);
`endif
    end
  end

endmodule
